// File: rtl/sfp_accum_pkg.sv
// Shared types and defaults for the SFP partial-sum accumulator.
package sfp_accum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int PSUM_BW_DEFAULT = 16;
  localparam int COL_DEFAULT     = 8;
  localparam int DEPTH_DEFAULT   = 16;

  // Low bit index of a lane inside a packed col-lane vector.
  function automatic int lane_lo(input int lane, input int bw);
    return lane * bw;
  endfunction

endpackage

// File: rtl/sfp_lane.sv
// One accumulator lane: overwrite-or-add on the write side, optional ReLU on
// the read side. Build option: SFP_RELU_EN clamps negative results to zero.
module sfp_lane
  import sfp_accum_pkg::*;
#(
  parameter int bw = PSUM_BW_DEFAULT
) (
  input  logic          first_pass,
  input  logic [bw-1:0] acc_lane,
  input  logic [bw-1:0] in_lane,
  input  logic [bw-1:0] rd_lane,
  output logic [bw-1:0] sum_lane,
  output logic [bw-1:0] out_lane
);

  // Pass 0 overwrites; later passes add. Two's-complement add wraps mod 2^bw.
  // NOTE: every output of an always_comb is assigned on every path, so no latch is inferred.
  always_comb begin
    sum_lane = first_pass ? in_lane : acc_lane + in_lane;
  end

  // Read-side transform; accumulation above never sees it.
  always_comb begin
`ifdef SFP_RELU_EN
    out_lane = rd_lane[bw-1] ? '0 : rd_lane;
`else
    out_lane = rd_lane;
`endif
  end

endmodule

// File: rtl/sfp_accum.sv
// Multi-pass vector accumulator fed from the corelet OFIFO, drained through a
// valid/ready result port. Build option: SFP_RELU_EN (ReLU on drained lanes).
module sfp_accum
  import sfp_accum_pkg::*;
#(
  parameter int psum_bw = PSUM_BW_DEFAULT,
  parameter int col     = COL_DEFAULT,
  parameter int depth   = DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_start,
  input  logic [3:0]               cfg_passes,
  input  logic [$clog2(depth):0]   cfg_len,
  input  logic [psum_bw*col-1:0]   in_data,
  input  logic                     in_valid,
  output logic                     o_rd,
  output logic [psum_bw*col-1:0]   out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     o_busy,
  output logic                     o_done
);

  localparam int AW = (depth > 1) ? $clog2(depth) : 1;
  localparam int LW = $clog2(depth) + 1;
  localparam int VW = psum_bw * col;

  typedef logic [VW-1:0] vec_t;

  state_t        state;
  logic [3:0]    passes_q;
  logic [3:0]    pass_q;
  logic [LW-1:0] len_q;
  logic [AW-1:0] addr;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] rd_sel;
  vec_t          acc [depth];
  vec_t          acc_cur;
  vec_t          acc_rd;
  vec_t          sum_vec;
  vec_t          out_vec;
  logic          consume;
  logic          first_pass;
  logic          last_addr;
  logic          last_pass;
  logic          last_rd;

  assign consume    = (state == ACCUM) && in_valid && !reset;
  assign o_rd       = consume;
  assign first_pass = (pass_q == 4'd0);
  assign last_addr  = (LW'(addr) == len_q - LW'(1));
  assign last_pass  = (pass_q == passes_q - 4'd1);
  assign last_rd    = (LW'(rd_addr) == len_q - LW'(1));
  // While a result is held, prefetch the next entry so a transfer can reload at once.
  assign rd_sel     = out_valid ? rd_addr + AW'(1) : rd_addr;
  assign acc_cur    = acc[addr];
  assign acc_rd     = acc[rd_sel];

  for (genvar i = 0; i < col; i++) begin : g_lane
    sfp_lane #(.bw(psum_bw)) u_lane (
      .first_pass (first_pass),
      .acc_lane   (acc_cur[lane_lo(i, psum_bw) +: psum_bw]),
      .in_lane    (in_data[lane_lo(i, psum_bw) +: psum_bw]),
      .rd_lane    (acc_rd[lane_lo(i, psum_bw) +: psum_bw]),
      .sum_lane   (sum_vec[lane_lo(i, psum_bw) +: psum_bw]),
      .out_lane   (out_vec[lane_lo(i, psum_bw) +: psum_bw])
    );
  end

  // Accumulator storage, written once per consumed vector.
  // NOTE: the array has no reset; pass 0 overwrites every entry before it can be read.
  always_ff @(posedge clk) begin
    if (consume) acc[addr] <= sum_vec;
  end

  // Job FSM with counters and registered result/status outputs.
  // NOTE: all state here uses non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      passes_q  <= '0;
      pass_q    <= '0;
      len_q     <= '0;
      addr      <= '0;
      rd_addr   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            passes_q <= (cfg_passes == 4'd0) ? 4'd1 : cfg_passes;
            len_q    <= (cfg_len == '0 || cfg_len > LW'(depth)) ? LW'(depth) : cfg_len;
            addr     <= '0;
            pass_q   <= '0;
            rd_addr  <= '0;
            o_busy   <= 1'b1;
            state    <= ACCUM;
          end
        end
        ACCUM: begin
          if (consume) begin
            if (last_addr) begin
              addr   <= '0;
              pass_q <= pass_q + 4'd1;
              if (last_pass) begin
                rd_addr <= '0;
                state   <= DRAIN;
              end
            end else begin
              addr <= addr + AW'(1);
            end
          end
        end
        DRAIN: begin
          if (!out_valid) begin
            out_data  <= out_vec;
            out_valid <= 1'b1;
          end else if (out_ready) begin
            if (last_rd) begin
              out_valid <= 1'b0;
              o_done    <= 1'b1;
              state     <= DONE;
            end else begin
              rd_addr  <= rd_addr + AW'(1);
              out_data <= out_vec;
            end
          end
        end
        DONE: begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sfp_accum.sv
// Self-checking bench for sfp_accum: directed scenarios plus randomized jobs
// compared against a plain-arithmetic sum-over-passes model.
`timescale 1ns/1ps
module tb_sfp_accum;

  localparam int BW    = 16;
  localparam int COL   = 8;
  localparam int DEPTH = 16;
  localparam int VW    = BW * COL;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_start;
  logic [3:0]    cfg_passes;
  logic [4:0]    cfg_len;
  logic [VW-1:0] in_data;
  logic          in_valid;
  logic          o_rd;
  logic [VW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          o_busy;
  logic          o_done;

  int n_checks = 0;
  int n_pass   = 0;

  logic [BW-1:0] stim  [240][COL];
  logic [BW-1:0] exp_v [DEPTH][COL];
  logic [BW-1:0] got   [DEPTH][COL];

  always #5 clk = ~clk;

  sfp_accum #(.psum_bw(BW), .col(COL), .depth(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_start    (i_start),
    .cfg_passes (cfg_passes),
    .cfg_len    (cfg_len),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .o_rd       (o_rd),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  function automatic logic [BW-1:0] relu(input logic [BW-1:0] v);
`ifdef SFP_RELU_EN
    return v[BW-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic [VW-1:0] pack_vec(input int k);
    logic [VW-1:0] v;
    for (int l = 0; l < COL; l++) v[l*BW +: BW] = stim[k][l];
    return v;
  endfunction

  function automatic logic [VW-1:0] pack_exp(input int a);
    logic [VW-1:0] v;
    for (int l = 0; l < COL; l++) v[l*BW +: BW] = exp_v[a][l];
    return v;
  endfunction

  // Reference: result[a] = sum over passes of input vector (pass*len + a), mod 2^BW.
  function automatic void build_expected(input int np, input int nl);
    for (int a = 0; a < nl; a++) begin
      for (int l = 0; l < COL; l++) begin
        logic [BW-1:0] s;
        s = '0;
        for (int p = 0; p < np; p++) s = s + stim[p*nl + a][l];
        exp_v[a][l] = relu(s);
      end
    end
  endfunction

  task automatic fill_random(input int n, input logic [BW-1:0] mask);
    for (int k = 0; k < n; k++)
      for (int l = 0; l < COL; l++) stim[k][l] = BW'($urandom) & mask;
  endtask

  // Runs one job from IDLE; rnd adds valid/ready gaps, noise toggles i_start/cfg mid-job.
  task automatic run_job(input logic [3:0] p_cfg, input logic [4:0] l_cfg,
                         input bit rnd, input bit noise);
    int np, nl, total, n_cons, n_xfer, done_cnt, done_cyc;
    int first_ov, last_cons, x_first, x_last, cyc;
    logic exp_rd;
    np    = (p_cfg == 4'd0) ? 1 : int'(p_cfg);
    nl    = (l_cfg == 5'd0 || int'(l_cfg) > DEPTH) ? DEPTH : int'(l_cfg);
    total = np * nl;
    build_expected(np, nl);
    n_cons = 0; n_xfer = 0; done_cnt = 0; done_cyc = -1;
    first_ov = -1; last_cons = -1; x_first = -1; x_last = -1; cyc = 0;

    @(negedge clk);
    i_start = 1'b1; cfg_passes = p_cfg; cfg_len = l_cfg; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    while (done_cnt == 0 && cyc < 4000) begin
      i_start = noise && ($urandom_range(0, 7) == 0);
      if (noise) begin
        cfg_passes = 4'($urandom);
        cfg_len    = 5'($urandom);
      end
      in_valid  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_data   = (in_valid && n_cons < total) ? pack_vec(n_cons)
                                               : {$urandom, $urandom, $urandom, $urandom};
      out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      #1;
      exp_rd = in_valid && (n_cons < total);
      n_checks++;
      if (o_rd !== exp_rd) $display("FAIL o_rd cyc=%0d got=%b exp=%b", cyc, o_rd, exp_rd);
      else n_pass++;
      n_checks++;
      if (o_busy !== 1'b1) $display("FAIL busy_in_job cyc=%0d got=%b exp=1", cyc, o_busy);
      else n_pass++;
      if (n_cons < total) begin
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL out_valid_in_accum cyc=%0d got=%b exp=0", cyc, out_valid);
        else n_pass++;
      end
      if (exp_rd && o_rd === 1'b1) begin
        n_cons++;
        last_cons = cyc;
      end
      if (out_valid === 1'b1 && first_ov < 0) first_ov = cyc;
      if (out_valid === 1'b1 && out_ready) begin
        if (x_first < 0) x_first = cyc;
        x_last = cyc;
        n_checks++;
        if (n_xfer >= nl) begin
          $display("FAIL extra_result cyc=%0d got=%0d results exp=%0d", cyc, n_xfer + 1, nl);
        end else begin
          for (int l = 0; l < COL; l++) got[n_xfer][l] = out_data[l*BW +: BW];
          if (out_data !== pack_exp(n_xfer))
            $display("FAIL result[%0d] got=%h exp=%h", n_xfer, out_data, pack_exp(n_xfer));
          else n_pass++;
        end
        n_xfer++;
      end
      if (o_done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
        i_start  = 1'b0;
      end
      cyc++;
      @(negedge clk);
    end
    i_start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    n_checks++;
    if (done_cnt != 1) $display("FAIL done_seen got=%0d exp=1 (timeout)", done_cnt);
    else n_pass++;
    n_checks++;
    if (n_xfer != nl) $display("FAIL result_count got=%0d exp=%0d", n_xfer, nl);
    else n_pass++;
    n_checks++;
    if (done_cyc != x_last + 1) $display("FAIL done_timing got=%0d exp=%0d", done_cyc, x_last + 1);
    else n_pass++;
    n_checks++;
    if (o_done !== 1'b0 || o_busy !== 1'b0)
      $display("FAIL idle_after_done got done=%b busy=%b exp 0/0", o_done, o_busy);
    else n_pass++;
    if (!rnd) begin
      n_checks++;
      if (first_ov != last_cons + 2)
        $display("FAIL first_latency got=%0d exp=%0d", first_ov - last_cons, 2);
      else n_pass++;
      n_checks++;
      if (x_last - x_first != nl - 1)
        $display("FAIL drain_throughput got=%0d exp=%0d", x_last - x_first, nl - 1);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; i_start = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    cfg_passes = '0; cfg_len = '0; in_data = '0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (o_rd !== 1'b0) $display("FAIL reset_o_rd got=%b exp=0", o_rd); else n_pass++;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else n_pass++;
    n_checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0)
      $display("FAIL reset_status got busy=%b done=%b exp 0/0", o_busy, o_done);
    else n_pass++;
    n_checks++;
    if (out_data !== '0) $display("FAIL reset_out_data got=%h exp=0", out_data); else n_pass++;
    reset = 1'b0;
    @(negedge clk);
    #1;
    n_checks++;
    if (o_rd !== 1'b0 || o_busy !== 1'b0)
      $display("FAIL idle_no_start got rd=%b busy=%b exp 0/0", o_rd, o_busy);
    else n_pass++;
    in_valid = 1'b0;
  endtask

  task automatic test_basic();
    for (int k = 0; k < 4; k++)
      for (int l = 0; l < COL; l++) stim[k][l] = BW'(k + 1);
    run_job(4'd1, 5'd4, 1'b0, 1'b0);
    for (int a = 0; a < 4; a++)
      for (int l = 0; l < COL; l++) begin
        n_checks++;
        if (got[a][l] !== BW'(a + 1)) $display("FAIL basic[%0d][%0d] got=%h exp=%h", a, l, got[a][l], a + 1);
        else n_pass++;
      end
  endtask

  task automatic test_multi_pass();
    for (int k = 0; k < 6; k++)
      for (int l = 0; l < COL; l++) stim[k][l] = 16'd5;
    run_job(4'd3, 5'd2, 1'b0, 1'b0);
    for (int a = 0; a < 2; a++) begin
      n_checks++;
      if (got[a][3] !== 16'd15) $display("FAIL multi_pass[%0d] got=%0d exp=15", a, got[a][3]);
      else n_pass++;
    end
  endtask

  task automatic test_signed();
    logic [BW-1:0] want;
    fill_random(2, 16'h0FFF);
    stim[0][0] = 16'hFFF9;
    stim[1][0] = 16'h0003;
`ifdef SFP_RELU_EN
    want = 16'h0000;
`else
    want = 16'hFFFC;
`endif
    run_job(4'd2, 5'd1, 1'b0, 1'b0);
    n_checks++;
    if (got[0][0] !== want) $display("FAIL signed_sum got=%h exp=%h", got[0][0], want);
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic [BW-1:0] want;
    fill_random(2, 16'h0FFF);
    stim[0][2] = 16'h7FFF;
    stim[1][2] = 16'h0001;
`ifdef SFP_RELU_EN
    want = 16'h0000;
`else
    want = 16'h8000;
`endif
    run_job(4'd2, 5'd1, 1'b0, 1'b0);
    n_checks++;
    if (got[0][2] !== want) $display("FAIL wrap got=%h exp=%h", got[0][2], want);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [VW-1:0] hold;
    int n, cyc;
    fill_random(3, 16'hFFFF);
    build_expected(1, 3);
    @(negedge clk);
    i_start = 1'b1; cfg_passes = 4'd1; cfg_len = 5'd3; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    i_start = 1'b0;
    n = 0; cyc = 0;
    while (out_valid !== 1'b1 && cyc < 100) begin
      in_valid = (n < 3);
      in_data  = pack_vec(n);
      #1;
      if (o_rd === 1'b1) n++;
      cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
    hold = out_data;
    n_checks++;
    if (out_valid !== 1'b1 || hold !== pack_exp(0))
      $display("FAIL bp_first got valid=%b data=%h exp 1/%h", out_valid, hold, pack_exp(0));
    else n_pass++;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== hold)
        $display("FAIL bp_hold[%0d] got valid=%b data=%h exp 1/%h", s, out_valid, out_data, hold);
      else n_pass++;
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== pack_exp(k))
        $display("FAIL bp_result[%0d] got valid=%b data=%h exp 1/%h", k, out_valid, out_data, pack_exp(k));
      else n_pass++;
      @(negedge clk);
      #1;
    end
    n_checks++;
    if (o_done !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL bp_done got done=%b valid=%b exp 1/0", o_done, out_valid);
    else n_pass++;
    out_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    fill_random(6, 16'hFFFF);
    @(negedge clk);
    i_start = 1'b1; cfg_passes = 4'd2; cfg_len = 5'd3; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    i_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data  = pack_vec(k);
      @(negedge clk);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (o_rd !== 1'b0) $display("FAIL mid_reset_o_rd got=%b exp=0", o_rd); else n_pass++;
    @(negedge clk);
    #1;
    n_checks++;
    if (o_busy !== 1'b0 || out_valid !== 1'b0 || o_done !== 1'b0 || out_data !== '0)
      $display("FAIL mid_reset_outputs got busy=%b valid=%b done=%b data=%h exp all 0",
               o_busy, out_valid, o_done, out_data);
    else n_pass++;
    reset = 1'b0; in_valid = 1'b0;
    fill_random(2, 16'h7FFF);
    run_job(4'd1, 5'd2, 1'b0, 1'b0);
    for (int a = 0; a < 2; a++)
      for (int l = 0; l < COL; l++) begin
        n_checks++;
        if (got[a][l] !== stim[a][l]) $display("FAIL fresh[%0d][%0d] got=%h exp=%h", a, l, got[a][l], stim[a][l]);
        else n_pass++;
      end
  endtask

  task automatic test_cfg_bounds();
    fill_random(16, 16'hFFFF);
    run_job(4'd0, 5'd0, 1'b0, 1'b0);
    fill_random(32, 16'hFFFF);
    run_job(4'd2, 5'd20, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    fill_random(6, 16'hFFFF);
    run_job(4'd2, 5'd3, 1'b0, 1'b0);
    fill_random(16, 16'hFFFF);
    run_job(4'd1, 5'd16, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int j = 0; j < 6; j++) begin
      fill_random(240, 16'hFFFF);
      run_job(4'($urandom), 5'($urandom), 1'b1, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_multi_pass();
    test_signed();
    test_wrap();
    test_backpressure();
    test_reset_mid();
    test_cfg_bounds();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sfp_accum.md
SFP_ACCUM -- requirements
Module: sfp_accum

Interface
REQ-001 Parameter psum_bw, default 16, SHALL set the per-lane partial-sum width.
REQ-002 Parameter col, default 8, SHALL set the lane count, matching corelet columns.
REQ-003 Parameter depth, default 16, SHALL set the accumulator entries, one col-lane vector each.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-006 i_start  input  1  SHALL be the start-of-job pulse.
REQ-007 cfg_passes  input  4  SHALL give the accumulation passes per job.
REQ-008 cfg_len  input  $clog2(depth)+1  SHALL give the vectors per pass.
REQ-009 in_data  input  psum_bw*col  SHALL carry the corelet OFIFO output vector.
REQ-010 in_valid  input  1  SHALL flag in_data as holding an unread vector.
REQ-011 o_rd  output  1  SHALL be the OFIFO read strobe; a vector is consumed when in_valid and o_rd are both high.
REQ-012 out_data  output  psum_bw*col  SHALL carry the result vector.
REQ-013 out_valid / out_ready  output / input  1 / 1  SHALL form the result handshake; a transfer occurs when both are high.
REQ-014 o_busy, o_done  output  1 each  SHALL flag job-in-progress and a one-cycle completion pulse.

Function
REQ-015 FSM SHALL have four states: IDLE, ACCUM, DRAIN, DONE.
REQ-016 In IDLE, i_start SHALL latch cfg_passes and cfg_len, clear the address and pass counters, and move to ACCUM next cycle.
REQ-017 A cfg_passes value of 0 SHALL be treated as 1; a cfg_len of 0 or above depth SHALL be treated as depth.
REQ-018 o_rd SHALL be combinational and equal (state==ACCUM && in_valid); all other states SHALL drive 0.
REQ-019 On each consume, pass 0 SHALL write acc[addr]=in_data; later passes SHALL write acc[addr]=acc[addr]+in_data, lane-wise, signed, wrapping modulo 2^psum_bw.
REQ-020 addr SHALL increment on each consume; at cfg_len-1 it SHALL wrap to 0 and pass SHALL increment.
REQ-021 The consume at the last address of the last pass SHALL move the FSM to DRAIN with rd_addr=0.
REQ-022 In DRAIN, out_valid SHALL be 1 and out_data SHALL be the registered acc[rd_addr] after the REQ-030 transform.
REQ-023 rd_addr SHALL advance only on a transfer; out_data SHALL hold stable while out_valid && !out_ready.
REQ-024 After the cfg_len-th transfer, FSM SHALL enter DONE, assert o_done for exactly one cycle, then return to IDLE.
REQ-025 o_busy SHALL be 1 in ACCUM, DRAIN, and DONE, and 0 in IDLE.
REQ-026 i_start outside IDLE SHALL be ignored; cfg changes outside IDLE SHALL have no effect.
REQ-027 in_valid low in ACCUM SHALL stall counters with no state change; there is no timeout.
REQ-028 First result latency SHALL be 1 cycle after entering DRAIN; throughput SHALL be one vector per cycle under continuous in_valid or out_ready.

Reset
REQ-029 reset SHALL force IDLE, clear all counters, and drive o_rd, out_valid, o_busy, and o_done to 0 and out_data to 0, including mid-job; accumulator contents are not cleared, since pass 0 overwrites them.

Configuration
REQ-030 With SFP_RELU_EN defined, each out_data lane with its MSB set SHALL output 0; without it, lanes SHALL pass unchanged; accumulation is unaffected in both cases.

Structure
REQ-031 A shared package SHALL hold the FSM state enum, default psum_bw/col/depth constants, and a lane-slice helper.
REQ-032 One sub-module, sfp_lane (per-lane add/overwrite and ReLU), SHALL be instantiated col times.

Verification
REQ-033 Scenario: passes=1, len=4, lane values 1..4, out_ready=1 -> outputs 1,2,3,4, one per cycle, then o_done.
REQ-034 Scenario: passes=3, len=2, each input all-lanes 5 -> outputs 15,15.
REQ-035 Scenario: -7 then +3 on one lane, passes=2, len=1 -> output 0 with SFP_RELU_EN, 0xFFFC without.
REQ-036 Scenario: out_ready held low 5 cycles in DRAIN -> out_data stable, rd_addr unchanged.
REQ-037 Scenario: 0x7FFF+0x0001 on one lane -> output 0x8000 without SFP_RELU_EN (wrap).
REQ-038 Scenario: reset asserted mid-ACCUM, then a new job of passes=1, len=2 -> fresh results with no stale sums.
